byte_serial_sub32: RTL and testbench
====================================

// Module: byte_serial_sub32
// PURPOSE
//  Multi-cycle subtractor: computes diff = a - b one SLICE-bit slice per clock, LSB slice first,
//  chaining the carry between slices through a register. It is the subtract counterpart to the
//  8-bit carry-lookahead adder slices. ALU/branch-compare path uses it for SUB/SUBU/SLT/SLTU
//  when area matters more than latency. Start/done handshake with the controller.
// PARAMETERS
//  WIDTH  32  operand/result width; must be an integer multiple of SLICE
//  SLICE   8  bits processed per clock
// PORTS
//  clk       in   1      system clock; all state updates on rising edge
//  rst       in   1      synchronous reset, active-high
//  start     in   1      request; operands sampled when start=1 and busy=0
//  a         in   WIDTH  minuend
//  b         in   WIDTH  subtrahend
//  busy      out  1      operation in progress
//  done      out  1      one-cycle pulse; results valid from this cycle on
//  diff      out  WIDTH  a - b (mod 2^WIDTH)
//  borrow    out  1      unsigned a < b (inverted final carry)
//  overflow  out  1      signed overflow of a - b
//  zero      out  1      diff == 0
// BEHAVIOUR
//  - One clock, synchronous active-high reset. rst=1 at an edge: state IDLE, slice index 0,
//    carry reg 0, operand regs 0, diff 0, busy 0, done 0, borrow 0, overflow 0, zero 0.
//  - NSLICE = WIDTH/SLICE (4 at defaults). FSM states: IDLE, RUN.
//  - IDLE & start=1: latch a, ~b; carry reg <= 1 (two's-complement +1); index <= 0; -> RUN.
//    start while busy=1 is ignored (no re-latch, no queueing). Cycle start=1 is sampled = cycle 0.
//  - RUN, cycle i+1 (i = 0..NSLICE-1): slice sum = a[i] + ~b[i] + carry;
//    diff[i*SLICE +: SLICE] <= sum; carry <= slice carry-out; index <= i+1. busy=1 in cycles 1..NSLICE.
//  - After the edge that writes slice NSLICE-1: -> IDLE; done=1 for exactly one cycle (cycle NSLICE+1).
//    In that same edge: borrow <= ~carry_out; overflow <= (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]);
//    zero <= (full diff == 0) using the just-written top slice.
//  - Latency: start in cycle 0 -> done in cycle NSLICE+1 (5 at defaults). A new start is accepted
//    in the done cycle (busy=0), giving one result per NSLICE+1 cycles back-to-back.
//  - diff/borrow/overflow/zero hold their value until the next accepted start; while RUN, diff
//    slices update progressively and flags keep the previous result.
//  - a/b may change after acceptance without effect (operand regs are private).
//  - rst mid-RUN: abandon operation, all outputs to reset values, no done pulse.
//  - Slice carry: c_out = g | (p & c_in) from the slice group generate/propagate.
// STRUCTURE
//  - Shared package/include: FSM state encodings (S_IDLE, S_RUN), SLICE default width.
//  - One sub-module: sub_slice (SLICE-bit CLA adder built from cla_4 + g_p, exposing c_out);
//    single instance, muxed to the current slice via index.
//  - Top: FSM, index counter (log2(NSLICE) bits), carry reg, operand regs, result/flag regs.
// TESTING
//  - 5 - 3 -> done in cycle 5; diff=0x00000002, borrow=0, overflow=0, zero=0.
//  - 3 - 5 -> diff=0xFFFFFFFE, borrow=1, overflow=0, zero=0.
//  - 0x80000000 - 0x00000001 -> diff=0x7FFFFFFF, overflow=1, borrow=0.
//  - 0x12345678 - 0x12345678 -> diff=0, zero=1, borrow=0; then 0x00000100 - 1 -> 0x000000FF
//    (borrow ripples through slice 0 into slice 1).
//  - start pulsed again in cycles 2 and 3 with other operands -> ignored; first result
//    unchanged; start in done cycle accepted, second done exactly 5 cycles later.
//  - rst asserted in cycle 3 of a RUN -> next cycle busy=0, done=0, diff=0, all flags 0;
//    no done pulse follows.

Source files
------------

// File: rtl/byte_serial_sub32_pkg.sv
// byte_serial_sub32_pkg
//   Shared definitions for the byte-serial subtractor.
//   state_t : controller states (S_IDLE, S_RUN)
//   SLICE_W : default number of bits handled per clock
package byte_serial_sub32_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam int SLICE_W = 8;

endpackage

// File: rtl/byte_serial_sub32_sub_slice.sv
// sub_slice
//   SLICE-bit carry-lookahead adder slice used for one step of a - b.
//   x, y   : slice operands (y is already the inverted subtrahend)
//   c_in   : carry into the slice
//   sum    : slice sum
//   c_out  : carry out, formed from the slice group generate/propagate
module sub_slice
   import byte_serial_sub32_pkg::*;
#(
   parameter int SLICE = SLICE_W
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             c_in,
   output logic [SLICE-1:0] sum,
   output logic             c_out
);

   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic             grp_g;
   logic             grp_p;
   logic             carry;

   always_comb begin
      g     = x & y;
      p     = x ^ y;
      sum   = '0;
      carry = c_in;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < SLICE; i++) begin
         sum[i] = p[i] ^ carry;
         carry  = g[i] | (p[i] & carry);
         grp_g  = g[i] | (p[i] & grp_g);
         grp_p  = grp_p & p[i];
      end
      c_out = grp_g | (grp_p & c_in);
   end

endmodule

// File: rtl/byte_serial_sub32.sv
// byte_serial_sub32
//   Multi-cycle subtractor: diff = a - b, one SLICE-bit slice per clock,
//   LSB slice first, carry chained through a register.
//   clk, rst        : clock, synchronous active-high reset
//   start, a, b     : request and operands (sampled when start=1 and busy=0)
//   busy, done      : operation in progress / one-cycle completion pulse
//   diff            : a - b mod 2^WIDTH
//   borrow          : unsigned a < b
//   overflow        : signed overflow of a - b
//   zero            : diff == 0
//
// state  | meaning
// S_IDLE | waiting for start; results and flags held
// S_RUN  | writing slice idx_q of diff each clock
module byte_serial_sub32
   import byte_serial_sub32_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = SLICE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
   localparam int MSB = WIDTH - 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   bn_q, bn_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               done_q, done_d;
   logic               borrow_q, borrow_d;
   logic               overflow_q, overflow_d;
   logic               zero_q, zero_d;

   logic [SLICE-1:0]   sl_x;
   logic [SLICE-1:0]   sl_y;
   logic [SLICE-1:0]   sl_sum;
   logic               sl_cout;

   assign sl_x = a_q[int'(idx_q)*SLICE +: SLICE];
   assign sl_y = bn_q[int'(idx_q)*SLICE +: SLICE];

   sub_slice #(.SLICE(SLICE)) u_slice (
      .x     (sl_x),
      .y     (sl_y),
      .c_in  (carry_q),
      .sum   (sl_sum),
      .c_out (sl_cout)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      a_d        = a_q;
      bn_d       = bn_q;
      diff_d     = diff_q;
      done_d     = 1'b0;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               bn_d    = ~b;
               carry_d = 1'b1;   // +1 completes the two's complement of b
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            diff_d[int'(idx_q)*SLICE +: SLICE] = sl_sum;
            carry_d = sl_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d    = S_IDLE;
               idx_d      = '0;
               done_d     = 1'b1;
               borrow_d   = ~sl_cout;
               // bn_q holds ~b, so the original sign of b is ~bn_q[MSB]
               overflow_d = (a_q[MSB] ^ ~bn_q[MSB]) & (a_q[MSB] ^ diff_d[MSB]);
               zero_d     = (diff_d == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         a_q        <= '0;
         bn_q       <= '0;
         diff_q     <= '0;
         done_q     <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         a_q        <= a_d;
         bn_q       <= bn_d;
         diff_q     <= diff_d;
         done_q     <= done_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign busy     = (state_q == S_RUN);
   assign done     = done_q;
   assign diff     = diff_q;
   assign borrow   = borrow_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_byte_serial_sub32.sv
module tb_byte_serial_sub32;

   localparam int NSLICE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, borrow, overflow, zero;
   logic [31:0] diff;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   byte_serial_sub32 dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff),
      .borrow(borrow), .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   // Behavioural model: result = a - b, revealed one byte per cycle.
   bit        m_busy, m_done, m_borrow, m_ovf, m_zero;
   bit        p_borrow, p_ovf, p_zero;
   bit [31:0] m_diff, m_res, m_prev;
   int        m_k;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_diff = 0; m_borrow = 0; m_ovf = 0; m_zero = 0; m_k = 0;
      end else begin
         m_done = 0;
         if (!m_busy && start) begin
            longint sd;
            m_busy   = 1;
            m_k      = 0;
            m_res    = a - b;
            m_prev   = m_diff;
            sd       = longint'($signed(a)) - longint'($signed(b));
            p_borrow = (a < b);
            p_ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            p_zero   = (a == b);
         end else if (m_busy) begin
            longint unsigned mask;
            m_k++;
            mask   = (64'd1 << (8 * m_k)) - 64'd1;
            m_diff = (m_res & mask[31:0]) | (m_prev & ~mask[31:0]);
            if (m_k == NSLICE) begin
               m_busy = 0; m_done = 1;
               m_borrow = p_borrow; m_ovf = p_ovf; m_zero = p_zero;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_busy", 32'(busy), 32'(m_busy));
         chk("model_done", 32'(done), 32'(m_done));
         chk("model_diff", diff, m_diff);
         chk("model_borrow", 32'(borrow), 32'(m_borrow));
         chk("model_overflow", 32'(overflow), 32'(m_ovf));
         chk("model_zero", 32'(zero), 32'(m_zero));
      end
   end

   // Waits for done; returns the cycle index (cycle 1 = first after acceptance).
   task automatic wait_done(input string nm, output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      if (lat == 0) begin
         n_chk++; n_err++;
         $display("FAIL %s_timeout: done never seen", nm);
      end
   endtask

   task automatic op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                     input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
      int lat;
      @(posedge clk); #2; start = 1; a = ta; b = tb_;
      @(posedge clk); #2; start = 0; a = $urandom; b = $urandom;
      wait_done(nm, lat);
      chk({nm, "_latency"}, 32'(lat), 32'(NSLICE + 1));
      chk({nm, "_diff"}, diff, ed);
      chk({nm, "_borrow"}, 32'(borrow), 32'(eb));
      chk({nm, "_overflow"}, 32'(overflow), 32'(eo));
      chk({nm, "_zero"}, 32'(zero), 32'(ez));
   endtask

   initial begin
      int lat;
      @(posedge clk); chk_en = 1'b1;
      @(posedge clk); #2;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", diff, 32'd0);
      chk("rst_flags", {29'd0, borrow, overflow, zero}, 32'd0);
      @(posedge clk); #2; rst = 0;

      op("sub_5_3", 32'd5, 32'd3, 32'h00000002, 0, 0, 0);
      op("sub_3_5", 32'd3, 32'd5, 32'hFFFFFFFE, 1, 0, 0);
      op("sub_ovf", 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0);
      op("sub_eq", 32'h12345678, 32'h12345678, 32'h00000000, 0, 0, 1);
      op("sub_ripple", 32'h00000100, 32'h00000001, 32'h000000FF, 0, 0, 0);

      // Back-to-back with starts ignored while busy.
      @(posedge clk); #2; start = 1; a = 32'd5; b = 32'd3;            // cycle 0
      @(posedge clk); #2; start = 0; a = 32'hDEADBEEF; b = 32'h1;     // cycle 1
      @(posedge clk); #2; start = 1; a = 32'h11111111; b = 32'h2;     // cycle 2
      @(posedge clk); #2; start = 1; a = 32'h0; b = 32'h77;           // cycle 3
      @(posedge clk); #2; start = 0;                                   // cycle 4
      @(posedge clk); #2; start = 1; a = 32'h00000100; b = 32'h1;     // cycle 5
      @(negedge clk);
      chk("b2b_first_done", 32'(done), 32'd1);
      chk("b2b_first_diff", diff, 32'h00000002);
      chk("b2b_first_busy", 32'(busy), 32'd0);
      @(posedge clk); #2; start = 0;                                   // cycle 6
      wait_done("b2b_second", lat);
      chk("b2b_second_latency", 32'(lat), 32'd5);                      // cycle 10
      chk("b2b_second_diff", diff, 32'h000000FF);

      // Reset in cycle 3 of a run.
      @(posedge clk); #2; start = 1; a = 32'hF0F0F0F0; b = 32'h01020304; // cycle 0
      @(posedge clk); #2; start = 0;                                      // cycle 1
      @(posedge clk); #2;                                                 // cycle 2
      @(posedge clk); #2; rst = 1;                                        // cycle 3
      @(posedge clk); #2; rst = 0;                                        // cycle 4
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_diff", diff, 32'd0);
      chk("midrst_flags", {29'd0, borrow, overflow, zero}, 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("midrst_no_done", 32'(seen), 32'd0);
      end

      @(posedge clk); #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
